// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module   : data_cache
// Brief    : Direct-mapped, write-back, write-allocate L1 data cache with
//            line-wide memory bus and hit/access performance counters.
// Revision : 1.0  initial release
// ============================================================================
module data_cache #(
   parameter int WORD_SIZE  = 16,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 4
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            cpu_read,
   input  logic                            cpu_write,
   input  logic [WORD_SIZE-1:0]            cpu_addr,
   input  logic [WORD_SIZE-1:0]            cpu_wdata,
   output logic [WORD_SIZE-1:0]            cpu_rdata,
   output logic                            cpu_ready,
   output logic                            mem_read,
   output logic                            mem_write,
   output logic [WORD_SIZE-1:0]            mem_addr,
   output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
   input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
   input  logic                            mem_ready,
   output logic [15:0]                     hit_count,
   output logic [15:0]                     acc_count
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

   typedef enum logic [1:0] {
      COMPARE   = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   // Word 0 of each line sits in the low bits, matching the memory bus layout.
   logic [LINE_WORDS-1:0][WORD_SIZE-1:0] r_data [NUM_LINES];
   logic [TAG_W-1:0]                     r_tag  [NUM_LINES];
   logic [NUM_LINES-1:0]                 r_valid;
   logic [NUM_LINES-1:0]                 r_dirty;
   logic                                 r_missed;

   logic [OFF_W-1:0]     w_off;
   logic [IDX_W-1:0]     w_idx;
   logic [TAG_W-1:0]     w_tag;
   logic                 w_req;
   logic                 w_hit;
   logic                 w_hit_write;
   logic                 w_wb_done;
   logic                 w_fill;
   logic                 w_set_missed;
   logic [WORD_SIZE-1:0] w_word;

   assign w_off  = cpu_addr[OFF_W-1:0];
   assign w_idx  = cpu_addr[OFF_W +: IDX_W];
   assign w_tag  = cpu_addr[WORD_SIZE-1 -: TAG_W];
   assign w_req  = cpu_read | cpu_write;
   assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_word = r_data[w_idx][w_off];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= COMPARE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      cpu_ready    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      w_hit_write  = 1'b0;
      w_wb_done    = 1'b0;
      w_fill       = 1'b0;
      w_set_missed = 1'b0;
      case (r_state)
         COMPARE: begin
            if (!w_req) begin
               cpu_ready = 1'b1;
            end else if (w_hit) begin
               cpu_ready   = 1'b1;
               w_hit_write = cpu_write;
            end else begin
               w_set_missed = 1'b1;
               w_next       = r_dirty[w_idx] ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            mem_write = 1'b1;
            mem_addr  = {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
            mem_wdata = r_data[w_idx];
            if (mem_ready) begin
               w_wb_done = 1'b1;
               w_next    = ALLOCATE;
            end
         end
         ALLOCATE: begin
            mem_read = 1'b1;
            mem_addr = {cpu_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
            if (mem_ready) begin
               w_fill = 1'b1;
               w_next = COMPARE;
            end
         end
         default: begin
            w_next = COMPARE;
         end
      endcase
      cpu_rdata = (cpu_ready && cpu_read) ? w_word : '0;
   end

   // Line storage needs no reset: the valid bits alone decide whether it is used.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (w_hit_write) begin
            r_data[w_idx][w_off] <= cpu_wdata;
         end
         if (w_fill) begin
            r_data[w_idx] <= mem_rdata;
            r_tag[w_idx]  <= w_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_valid   <= '0;
         r_dirty   <= '0;
         r_missed  <= 1'b0;
         hit_count <= 16'd0;
         acc_count <= 16'd0;
      end else begin
         if (w_hit_write) begin
            r_dirty[w_idx] <= 1'b1;
         end
         if (w_wb_done) begin
            r_dirty[w_idx] <= 1'b0;
         end
         if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
         end
         // An access that stalled earlier finishes later as a hit; missed keeps it out of hit_count.
         if (w_req && cpu_ready) begin
            acc_count <= acc_count + 16'd1;
            if (!r_missed) begin
               hit_count <= hit_count + 16'd1;
            end
            r_missed <= 1'b0;
         end else if (w_set_missed) begin
            r_missed <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// Testbench for data_cache: directed scenarios plus randomized traffic checked
// against a flat word-memory reference with a direct-mapped residency model.
module tb_data_cache;

   logic        clk;
   logic        reset_n;
   logic        cpu_read;
   logic        cpu_write;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ready;
   logic [15:0] hit_count;
   logic [15:0] acc_count;

   data_cache dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_read  (cpu_read),
      .cpu_write (cpu_write),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .hit_count (hit_count),
      .acc_count (acc_count)
   );

   int checks = 0;
   int failures = 0;

   // Memory side: mem_ready pulses on the resp_delay-th cycle a request is held.
   int          resp_delay = 2;
   int          busy_cycles = 0;
   int          wb_count = 0;
   int          rd_count = 0;
   int          both_err = 0;
   int          misalign_err = 0;
   logic [15:0] last_rd_addr = '0;
   logic [15:0] last_wb_addr = '0;
   logic [63:0] last_wb_data = '0;
   logic [15:0] bmem    [logic [15:0]];
   logic [15:0] ref_mem [logic [15:0]];

   // Reference: which line each index holds, plus the CPU-visible memory image.
   bit          m_valid [4];
   bit          m_dirty [4];
   logic [11:0] m_tag   [4];
   logic [15:0] exp_acc = '0;
   logic [15:0] exp_hits = '0;
   bit          exp_hit;
   bit          exp_wb;
   int          exp_stall;
   logic [15:0] exp_rdata;
   logic [15:0] exp_wb_addr;
   logic [63:0] exp_wb_data;

   int          obs_stall;
   int          obs_wb;
   int          obs_rd;
   bit          obs_memreq;
   logic [15:0] obs_rdata;
   logic [15:0] obs_acc;
   logic [15:0] obs_hit;

   function automatic logic [15:0] dflt(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] bmem_rd(input logic [15:0] a);
      return bmem.exists(a) ? bmem[a] : dflt(a);
   endfunction

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         #1;
         mem_ready = 1'b0;
         if (reset_n === 1'b1 && (mem_read === 1'b1 || mem_write === 1'b1)) begin
            if (mem_read && mem_write) both_err++;
            if (mem_addr[1:0] != 2'b00) misalign_err++;
            busy_cycles++;
            if (busy_cycles >= resp_delay) begin
               busy_cycles = 0;
               mem_ready   = 1'b1;
               if (mem_write) begin
                  wb_count++;
                  last_wb_addr = mem_addr;
                  last_wb_data = mem_wdata;
                  for (int w = 0; w < 4; w++) bmem[mem_addr + 16'(w)] = mem_wdata[16*w +: 16];
               end else begin
                  rd_count++;
                  last_rd_addr = mem_addr;
                  for (int w = 0; w < 4; w++) mem_rdata[16*w +: 16] = bmem_rd(mem_addr + 16'(w));
               end
            end
         end else begin
            busy_cycles = 0;
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
      end
      exp_acc  = '0;
      exp_hits = '0;
      ref_mem  = bmem;
   endtask

   // Stall = one compare cycle plus resp_delay cycles per line transfer.
   task automatic model_access(input logic rd, input logic wr, input logic [15:0] a,
                               input logic [15:0] wd, input int d);
      int i;
      i = int'(a[3:2]);
      exp_hit = m_valid[i] && (m_tag[i] == a[15:4]);
      exp_wb  = !exp_hit && m_valid[i] && m_dirty[i];
      exp_wb_addr = {m_tag[i], a[3:2], 2'b00};
      for (int w = 0; w < 4; w++) exp_wb_data[16*w +: 16] = ref_rd(exp_wb_addr + 16'(w));
      exp_stall = exp_hit ? 0 : (exp_wb ? 2 * d + 1 : d + 1);
      if (!exp_hit) begin
         m_valid[i] = 1'b1;
         m_tag[i]   = a[15:4];
         m_dirty[i] = 1'b0;
      end
      exp_rdata = ref_rd(a);
      if (wr) begin
         ref_mem[a] = wd;
         m_dirty[i] = 1'b1;
      end
      exp_acc++;
      if (exp_hit) exp_hits++;
   endtask

   task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [15:0] wd, input int d);
      int wb0;
      int rd0;
      bit timeout;
      @(negedge clk);
      cpu_read   = rd;
      cpu_write  = wr;
      cpu_addr   = a;
      cpu_wdata  = wd;
      resp_delay = d;
      wb0 = wb_count;
      rd0 = rd_count;
      obs_stall = 0;
      timeout = 1'b0;
      #1;
      while (cpu_ready !== 1'b1) begin
         obs_stall++;
         if (obs_stall > 200) begin
            timeout = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      obs_rdata  = cpu_rdata;
      obs_memreq = mem_read | mem_write;
      if (!timeout) @(posedge clk);
      #1;
      obs_acc = acc_count;
      obs_hit = hit_count;
      obs_wb  = wb_count - wb0;
      obs_rd  = rd_count - rd0;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n   = 1'b0;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", cpu_ready); end
      checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
      checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
      checks++; if (acc_count !== 16'h0) begin failures++; $display("FAIL reset_acc: got %h expected 0000", acc_count); end
      checks++; if (hit_count !== 16'h0) begin failures++; $display("FAIL reset_hit: got %h expected 0000", hit_count); end
      checks++; if (cpu_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0000", cpu_rdata); end
   endtask

   task automatic test_cold_read();
      for (int w = 0; w < 4; w++) begin
         bmem[16'h0010 + 16'(w)]    = 16'(w + 1);
         ref_mem[16'h0010 + 16'(w)] = 16'(w + 1);
      end
      model_access(1'b1, 1'b0, 16'h0012, 16'h0, 3);
      do_access(1'b1, 1'b0, 16'h0012, 16'h0, 3);
      checks++; if (obs_stall !== 4) begin failures++; $display("FAIL cold_stall: got %0d expected 4", obs_stall); end
      checks++; if (obs_rd !== 1) begin failures++; $display("FAIL cold_fills: got %0d expected 1", obs_rd); end
      checks++; if (last_rd_addr !== 16'h0010) begin failures++; $display("FAIL cold_fill_addr: got %h expected 0010", last_rd_addr); end
      checks++; if (obs_rdata !== 16'h0003) begin failures++; $display("FAIL cold_rdata: got %h expected 0003", obs_rdata); end
      checks++; if (obs_hit !== 16'h0) begin failures++; $display("FAIL cold_hit_count: got %h expected 0000", obs_hit); end
      checks++; if (obs_acc !== 16'h1) begin failures++; $display("FAIL cold_acc_count: got %h expected 0001", obs_acc); end
   endtask

   task automatic test_hit_read();
      model_access(1'b1, 1'b0, 16'h0013, 16'h0, 3);
      do_access(1'b1, 1'b0, 16'h0013, 16'h0, 3);
      checks++; if (obs_stall !== 0) begin failures++; $display("FAIL hit_stall: got %0d expected 0", obs_stall); end
      checks++; if (obs_rdata !== 16'h0004) begin failures++; $display("FAIL hit_rdata: got %h expected 0004", obs_rdata); end
      checks++; if (obs_memreq !== 1'b0) begin failures++; $display("FAIL hit_memreq: got %b expected 0", obs_memreq); end
      checks++; if (obs_hit !== 16'h1) begin failures++; $display("FAIL hit_hit_count: got %h expected 0001", obs_hit); end
   endtask

   task automatic test_dirty_evict();
      model_access(1'b0, 1'b1, 16'h0011, 16'hBEEF, 2);
      do_access(1'b0, 1'b1, 16'h0011, 16'hBEEF, 2);
      checks++; if (obs_stall !== 0) begin failures++; $display("FAIL store_hit_stall: got %0d expected 0", obs_stall); end
      model_access(1'b1, 1'b0, 16'h0051, 16'h0, 2);
      do_access(1'b1, 1'b0, 16'h0051, 16'h0, 2);
      checks++; if (obs_wb !== 1) begin failures++; $display("FAIL evict_wb: got %0d expected 1", obs_wb); end
      checks++; if (last_wb_addr !== 16'h0010) begin failures++; $display("FAIL evict_wb_addr: got %h expected 0010", last_wb_addr); end
      checks++; if (last_wb_data[31:16] !== 16'hBEEF) begin failures++; $display("FAIL evict_wb_word1: got %h expected beef", last_wb_data[31:16]); end
      checks++; if (last_wb_data !== exp_wb_data) begin failures++; $display("FAIL evict_wb_line: got %h expected %h", last_wb_data, exp_wb_data); end
      checks++; if (last_rd_addr !== 16'h0050) begin failures++; $display("FAIL evict_fill_addr: got %h expected 0050", last_rd_addr); end
      checks++; if (obs_stall !== exp_stall) begin failures++; $display("FAIL evict_stall: got %0d expected %0d", obs_stall, exp_stall); end
      checks++; if (obs_rdata !== exp_rdata) begin failures++; $display("FAIL evict_rdata: got %h expected %h", obs_rdata, exp_rdata); end
      // The freshly filled line must be clean: evicting it needs no writeback.
      model_access(1'b1, 1'b0, 16'h0091, 16'h0, 2);
      do_access(1'b1, 1'b0, 16'h0091, 16'h0, 2);
      checks++; if (obs_wb !== 0) begin failures++; $display("FAIL clean_evict_wb: got %0d expected 0", obs_wb); end
      checks++; if (obs_stall !== 3) begin failures++; $display("FAIL clean_evict_stall: got %0d expected 3", obs_stall); end
   endtask

   task automatic test_read_write_both();
      model_access(1'b1, 1'b1, 16'h0091, 16'h1234, 2);
      do_access(1'b1, 1'b1, 16'h0091, 16'h1234, 2);
      checks++; if (obs_stall !== 0) begin failures++; $display("FAIL both_stall: got %0d expected 0", obs_stall); end
      model_access(1'b1, 1'b0, 16'h0091, 16'h0, 2);
      do_access(1'b1, 1'b0, 16'h0091, 16'h0, 2);
      checks++; if (obs_rdata !== 16'h1234) begin failures++; $display("FAIL both_readback: got %h expected 1234", obs_rdata); end
   endtask

   task automatic test_reset_during_allocate();
      @(negedge clk);
      cpu_read   = 1'b1;
      cpu_write  = 1'b0;
      cpu_addr   = 16'h0124;
      resp_delay = 20;
      @(negedge clk);
      #1;
      checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL alloc_pending: got %b expected 1", mem_read); end
      @(negedge clk);
      reset_n  = 1'b0;
      cpu_read = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL abort_mem_read: got %b expected 0", mem_read); end
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", cpu_ready); end
      checks++; if (acc_count !== 16'h0) begin failures++; $display("FAIL abort_acc: got %h expected 0000", acc_count); end
      checks++; if (hit_count !== 16'h0) begin failures++; $display("FAIL abort_hit: got %h expected 0000", hit_count); end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      // 0x0091 hit before the reset and held dirty data 0x1234 that is now lost.
      model_access(1'b1, 1'b0, 16'h0091, 16'h0, 2);
      do_access(1'b1, 1'b0, 16'h0091, 16'h0, 2);
      checks++; if (obs_stall !== 3) begin failures++; $display("FAIL abort_remiss_stall: got %0d expected 3", obs_stall); end
      checks++; if (obs_rdata !== exp_rdata) begin failures++; $display("FAIL abort_discard: got %h expected %h", obs_rdata, exp_rdata); end
   endtask

   task automatic test_random();
      logic        rd;
      logic        wr;
      logic [15:0] a;
      logic [15:0] wd;
      int          d;
      int          op;
      for (int n = 0; n < 200; n++) begin
         op = int'($urandom_range(0, 2));
         rd = (op != 1);
         wr = (op != 0);
         a  = {12'(12'h100 + $urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         wd = 16'($urandom);
         d  = int'($urandom_range(1, 4));
         if ($urandom_range(0, 4) == 0) idle_cycle();
         model_access(rd, wr, a, wd, d);
         do_access(rd, wr, a, wd, d);
         checks++; if (obs_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", n, obs_stall, exp_stall); end
         if (rd && !wr) begin
            checks++; if (obs_rdata !== exp_rdata) begin failures++; $display("FAIL rnd_rdata[%0d] addr %h: got %h expected %h", n, a, obs_rdata, exp_rdata); end
         end
         checks++; if (obs_wb !== int'(exp_wb)) begin failures++; $display("FAIL rnd_wb[%0d]: got %0d expected %0d", n, obs_wb, exp_wb); end
         if (exp_wb) begin
            checks++; if (last_wb_addr !== exp_wb_addr) begin failures++; $display("FAIL rnd_wb_addr[%0d]: got %h expected %h", n, last_wb_addr, exp_wb_addr); end
            checks++; if (last_wb_data !== exp_wb_data) begin failures++; $display("FAIL rnd_wb_data[%0d]: got %h expected %h", n, last_wb_data, exp_wb_data); end
         end
         checks++; if (obs_rd !== int'(!exp_hit)) begin failures++; $display("FAIL rnd_fill[%0d]: got %0d expected %0d", n, obs_rd, !exp_hit); end
         if (!exp_hit) begin
            checks++; if (last_rd_addr !== {a[15:2], 2'b00}) begin failures++; $display("FAIL rnd_fill_addr[%0d]: got %h expected %h", n, last_rd_addr, {a[15:2], 2'b00}); end
         end
         checks++; if (obs_acc !== exp_acc) begin failures++; $display("FAIL rnd_acc[%0d]: got %h expected %h", n, obs_acc, exp_acc); end
         checks++; if (obs_hit !== exp_hits) begin failures++; $display("FAIL rnd_hits[%0d]: got %h expected %h", n, obs_hit, exp_hits); end
      end
      idle_cycle();
   endtask

   task automatic test_protocol();
      checks++; if (both_err !== 0) begin failures++; $display("FAIL mem_rd_wr_overlap: got %0d cycles expected 0", both_err); end
      checks++; if (misalign_err !== 0) begin failures++; $display("FAIL mem_addr_align: got %0d cycles expected 0", misalign_err); end
   endtask

   task automatic test_counter_wrap();
      int          notready;
      logic [15:0] a;
      a = 16'h0233;
      apply_reset();
      model_access(1'b1, 1'b0, a, 16'h0, 2);
      do_access(1'b1, 1'b0, a, 16'h0, 2);
      @(negedge clk);
      cpu_read  = 1'b1;
      cpu_write = 1'b0;
      cpu_addr  = a;
      notready  = 0;
      for (int k = 0; k < 16'hFFFE; k++) begin
         #1;
         if (cpu_ready !== 1'b1) notready++;
         @(negedge clk);
      end
      cpu_read = 1'b0;
      exp_acc  = exp_acc + 16'hFFFE;
      exp_hits = exp_hits + 16'hFFFE;
      #1;
      checks++; if (notready !== 0) begin failures++; $display("FAIL wrap_stream_stalls: got %0d expected 0", notready); end
      checks++; if (acc_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_acc_pre: got %h expected ffff", acc_count); end
      checks++; if (hit_count !== exp_hits) begin failures++; $display("FAIL wrap_hit_pre: got %h expected %h", hit_count, exp_hits); end
      model_access(1'b1, 1'b0, a, 16'h0, 2);
      do_access(1'b1, 1'b0, a, 16'h0, 2);
      checks++; if (obs_acc !== 16'h0000) begin failures++; $display("FAIL wrap_acc: got %h expected 0000", obs_acc); end
      checks++; if (obs_hit !== exp_hits) begin failures++; $display("FAIL wrap_hit: got %h expected %h", obs_hit, exp_hits); end
      checks++; if (obs_stall !== 0) begin failures++; $display("FAIL wrap_stall: got %0d expected 0", obs_stall); end
      checks++; if (obs_rdata !== exp_rdata) begin failures++; $display("FAIL wrap_rdata: got %h expected %h", obs_rdata, exp_rdata); end
      model_access(1'b1, 1'b0, a, 16'h0, 2);
      do_access(1'b1, 1'b0, a, 16'h0, 2);
      checks++; if (obs_acc !== exp_acc) begin failures++; $display("FAIL wrap_acc_post: got %h expected %h", obs_acc, exp_acc); end
      checks++; if (obs_hit !== exp_hits) begin failures++; $display("FAIL wrap_hit_post: got %h expected %h", obs_hit, exp_hits); end
      idle_cycle();
   endtask

   initial begin
      reset_n   = 1'b0;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      test_reset();
      test_cold_read();
      test_hit_read();
      test_dirty_evict();
      test_read_write_both();
      test_reset_during_allocate();
      test_random();
      test_counter_wrap();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
